// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl -- position controller for a mouse-dropped rectangle.
//
// While idle the rectangle follows the mouse pointer (y limited to the floor).
// Pressing the left button freezes it and drops it under constant
// acceleration, advancing once per frame on the rising edge of vsync_in.
// On landing it either stops, or bounces back up with half its speed.
//
// Build option:
//   DRAW_RECT_CTL_BOUNCE_EN  defined   -> landing halves the velocity and
//                                         rises again while it is non-zero
//                            undefined -> landing stops the rectangle dead
//
// Parameters:
//   SCREEN_H  visible lines per frame
//   RECT_H    rectangle height in lines
//   G_ACCEL   velocity increment per frame (lines/frame)
//   VMAX      velocity saturation value
//
// Ports:
//   pclk        pixel clock, all logic on its rising edge
//   rst         asynchronous active-high reset
//   vsync_in    frame sync from the timing stage
//   mouse_left  drop request (level)
//   mouse_xpos  pointer x
//   mouse_ypos  pointer y
//   xpos        registered rectangle top-left x
//   ypos        registered rectangle top-left y
module draw_rect_ctl #(
  parameter int SCREEN_H = 768,
  parameter int RECT_H   = 64,
  parameter int G_ACCEL  = 1,
  parameter int VMAX     = 63
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos
);

  localparam logic [11:0] FLOOR   = 12'(SCREEN_H - RECT_H);
  localparam logic [8:0]  ACCEL   = 9'(G_ACCEL);
  localparam logic [7:0]  VEL_MAX = 8'(VMAX);

  typedef enum logic [1:0] {IDLE, FALL, RISE, STOP} state_t;

  state_t     state_reg;
  logic [7:0] vel_reg;
  logic       vsync_prev_reg;
  logic       armed_reg;
  logic       tick;

  // armed_reg blocks the first cycle after reset: vsync_prev_reg is cleared
  // by reset, so a vsync_in that was already high would otherwise look like
  // a fresh rising edge.
  assign tick = vsync_in & ~vsync_prev_reg & armed_reg;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_prev_reg <= 1'b0;
      armed_reg      <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync_in;
      armed_reg      <= 1'b1;
    end
  end

  // Motion arithmetic, widened by one bit so sums never wrap before the
  // comparisons that decide saturation and landing.
  logic [8:0]  vel_sum;
  logic [7:0]  vel_up;
  logic [12:0] y_down_sum;
  logic        landed;
  logic        rise_done;
  logic [7:0]  vel_dn;
  logic [11:0] y_up;
  logic [11:0] mouse_y_clamped;
  logic [7:0]  vel_land;

  always_comb begin
    vel_sum         = {1'b0, vel_reg} + ACCEL;
    vel_up          = (vel_sum > {1'b0, VEL_MAX}) ? VEL_MAX : vel_sum[7:0];
    y_down_sum      = {1'b0, ypos} + {5'd0, vel_up};
    landed          = (y_down_sum >= {1'b0, FLOOR});
    rise_done       = ({1'b0, vel_reg} <= ACCEL);
    vel_dn          = vel_reg - ACCEL[7:0];
    y_up            = (ypos >= {4'd0, vel_dn}) ? (ypos - {4'd0, vel_dn}) : 12'd0;
    mouse_y_clamped = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    vel_land        = vel_up >> 1;
`else
    vel_land        = 8'd0;
`endif
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      xpos      <= 12'd0;
      ypos      <= 12'd0;
      vel_reg   <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          vel_reg <= 8'd0;
          if (mouse_left) begin
            // Position stays frozen at the last tracked value; any tick in
            // this cycle is deliberately ignored.
            state_reg <= FALL;
          end else begin
            xpos <= mouse_xpos;
            ypos <= mouse_y_clamped;
          end
        end
        FALL: begin
          if (tick) begin
            if (landed) begin
              ypos    <= FLOOR;
              vel_reg <= vel_land;
              state_reg <= (vel_land != 8'd0) ? RISE : STOP;
            end else begin
              vel_reg <= vel_up;
              ypos    <= y_down_sum[11:0];
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (rise_done) begin
              // Apex reached: turn round without moving this frame.
              vel_reg   <= 8'd0;
              state_reg <= FALL;
            end else begin
              vel_reg <= vel_dn;
              ypos    <= y_up;
            end
          end
        end
        STOP: begin
          if (!mouse_left) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Self-checking bench for draw_rect_ctl.
// Two instances share all inputs: dut_a uses default parameters, dut_b uses
// SCREEN_H=4096 so its fall runs long enough to reach velocity saturation.
module tb_draw_rect_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync_in;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;

  always #5 pclk = ~pclk;

  draw_rect_ctl dut_a (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos_a), .ypos(ypos_a)
  );

  draw_rect_ctl #(.SCREEN_H(4096)) dut_b (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos_b), .ypos(ypos_b)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (frame-level motion rules) -------------
  localparam int G  = 1;
  localparam int VM = 63;
  localparam int M_IDLE = 0, M_FALL = 1, M_RISE = 2, M_STOP = 3;

  int m_mode [2];
  int m_x    [2];
  int m_y    [2];
  int m_v    [2];
  int m_floor[2] = '{704, 4032};
  int m_prev;
  int m_armed;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_x[i] = 0; m_y[i] = 0; m_v[i] = 0;
    end
    m_prev  = 0;
    m_armed = 0;
  endtask

  // One rising clock edge with the inputs currently applied.
  task automatic model_clock();
    bit tick;
    int nv;
    if (rst) begin
      model_reset();
      return;
    end
    tick    = (vsync_in == 1'b1) && (m_prev == 0) && (m_armed == 1);
    m_prev  = int'(vsync_in);
    m_armed = 1;
    for (int i = 0; i < 2; i++) begin
      case (m_mode[i])
        M_IDLE: begin
          m_v[i] = 0;
          if (mouse_left) m_mode[i] = M_FALL;
          else begin
            m_x[i] = int'(mouse_xpos);
            m_y[i] = (int'(mouse_ypos) < m_floor[i]) ? int'(mouse_ypos) : m_floor[i];
          end
        end
        M_FALL: if (tick) begin
          nv = (m_v[i] + G < VM) ? m_v[i] + G : VM;
          if (m_y[i] + nv >= m_floor[i]) begin
            m_y[i] = m_floor[i];
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            m_v[i]    = nv / 2;
            m_mode[i] = (m_v[i] != 0) ? M_RISE : M_STOP;
`else
            m_v[i]    = 0;
            m_mode[i] = M_STOP;
`endif
          end else begin
            m_v[i] = nv;
            m_y[i] = m_y[i] + nv;
          end
        end
        M_RISE: if (tick) begin
          if (m_v[i] <= G) begin
            m_v[i] = 0;
            m_mode[i] = M_FALL;
          end else begin
            m_v[i] = m_v[i] - G;
            m_y[i] = (m_y[i] > m_v[i]) ? m_y[i] - m_v[i] : 0;
          end
        end
        default: if (!mouse_left) m_mode[i] = M_IDLE;
      endcase
    end
  endtask

  // Advance one clock and compare both instances against the model.
  task automatic tick_cycle();
    model_clock();
    @(posedge pclk);
    @(negedge pclk);
    check("model_xpos_a", int'(xpos_a), m_x[0]);
    check("model_ypos_a", int'(ypos_a), m_y[0]);
    check("model_xpos_b", int'(xpos_b), m_x[1]);
    check("model_ypos_b", int'(ypos_b), m_y[1]);
  endtask

  // One frame: vsync high for a cycle, then low; mouse wiggles meanwhile.
  task automatic pulse();
    vsync_in   = 1'b1;
    mouse_xpos = 12'($urandom_range(0, 4095));
    mouse_ypos = 12'($urandom_range(0, 4095));
    tick_cycle();
    vsync_in = 1'b0;
    tick_cycle();
    tick_cycle();
  endtask

  // ---------------- tracking vectors ----------------
  typedef struct {
    logic [11:0] mx;
    logic [11:0] my;
    logic [11:0] ex;
    logic [11:0] ey_a;
    logic [11:0] ey_b;
  } trk_vec_t;

  trk_vec_t tbl [6];

  initial begin
    int exp_a, exp_b, frame_len, frame_pos;

    tbl[0] = '{mx: 12'd100,  my: 12'd200,  ex: 12'd100,  ey_a: 12'd200, ey_b: 12'd200};
    tbl[1] = '{mx: 12'd5,    my: 12'd750,  ex: 12'd5,    ey_a: 12'd704, ey_b: 12'd750};
    tbl[2] = '{mx: 12'd4095, my: 12'd704,  ex: 12'd4095, ey_a: 12'd704, ey_b: 12'd704};
    tbl[3] = '{mx: 12'd0,    my: 12'd705,  ex: 12'd0,    ey_a: 12'd704, ey_b: 12'd705};
    tbl[4] = '{mx: 12'd7,    my: 12'd0,    ex: 12'd7,    ey_a: 12'd0,   ey_b: 12'd0};
    tbl[5] = '{mx: 12'd640,  my: 12'd4095, ex: 12'd640,  ey_a: 12'd704, ey_b: 12'd4032};

    rst = 1'b1; vsync_in = 1'b0; mouse_left = 1'b0;
    mouse_xpos = 12'd321; mouse_ypos = 12'd123;
    model_reset();
    @(negedge pclk);
    tick_cycle();
    tick_cycle();
    check("reset_xpos", int'(xpos_a), 0);
    check("reset_ypos", int'(ypos_a), 0);
    $display("reset: xpos=%0d ypos=%0d", xpos_a, ypos_a);
    rst = 1'b0;

    // Tracking with floor clamp.
    for (int i = 0; i < 6; i++) begin
      mouse_xpos = tbl[i].mx;
      mouse_ypos = tbl[i].my;
      tick_cycle();
      check("track_x",   int'(xpos_a), int'(tbl[i].ex));
      check("track_y_a", int'(ypos_a), int'(tbl[i].ey_a));
      check("track_y_b", int'(ypos_b), int'(tbl[i].ey_b));
      $display("track: mouse=(%0d,%0d) a=(%0d,%0d) b_y=%0d",
               tbl[i].mx, tbl[i].my, xpos_a, ypos_a, ypos_b);
    end

    // Drop from y=0 with the press coinciding with a tick.
    mouse_xpos = 12'd50; mouse_ypos = 12'd0;
    tick_cycle();
    mouse_left = 1'b1; vsync_in = 1'b1;
    tick_cycle();
    check("simul_y_a", int'(ypos_a), 0);
    check("simul_x_a", int'(xpos_a), 50);
    check("simul_y_b", int'(ypos_b), 0);
    $display("press+tick: a=(%0d,%0d)", xpos_a, ypos_a);
    vsync_in = 1'b0;
    tick_cycle();

    for (int n = 1; n <= 70; n++) begin
      pulse();
      exp_b = (n <= 63) ? n * (n + 1) / 2 : 2016 + 63 * (n - 63);
      check("sat_fall_y_b", int'(ypos_b), exp_b);
      if (n <= 38) begin
        exp_a = (n * (n + 1) / 2 < 704) ? n * (n + 1) / 2 : 704;
        check("fall_y_a", int'(ypos_a), exp_a);
        check("fall_x_a", int'(xpos_a), 50);
      end else if (n == 39) begin
`ifdef DRAW_RECT_CTL_BOUNCE_EN
        check("bounce_y_a", int'(ypos_a), 686);
`else
        check("stop_y_a", int'(ypos_a), 704);
`endif
      end
      $display("frame %0d: a_y=%0d b_y=%0d", n, ypos_a, ypos_b);
    end

`ifndef DRAW_RECT_CTL_BOUNCE_EN
    check("stop_held_y_a", int'(ypos_a), 704);
    mouse_left = 1'b0; mouse_xpos = 12'd77; mouse_ypos = 12'd99;
    tick_cycle();
    tick_cycle();
    check("release_x_a", int'(xpos_a), 77);
    check("release_y_a", int'(ypos_a), 99);
    $display("release: a=(%0d,%0d)", xpos_a, ypos_a);
`endif

    // Asynchronous reset mid-fall at y=300.
    rst = 1'b1; mouse_left = 1'b0;
    tick_cycle();
    rst = 1'b0; mouse_xpos = 12'd33; mouse_ypos = 12'd0;
    tick_cycle();
    mouse_left = 1'b1;
    tick_cycle();
    for (int n = 1; n <= 24; n++) pulse();
    check("pre_rst_y_a", int'(ypos_a), 300);
    #2 rst = 1'b1;
    #1;
    check("async_rst_x_a", int'(xpos_a), 0);
    check("async_rst_y_a", int'(ypos_a), 0);
    $display("async reset: a=(%0d,%0d)", xpos_a, ypos_a);
    model_reset();
    @(negedge pclk);
    rst = 1'b0; mouse_left = 1'b0; mouse_xpos = 12'd123; mouse_ypos = 12'd456;
    tick_cycle();
    check("resume_x_a", int'(xpos_a), 123);
    check("resume_y_a", int'(ypos_a), 456);
    $display("resume: a=(%0d,%0d)", xpos_a, ypos_a);

    // vsync already high across reset release must not produce a tick.
    rst = 1'b1; vsync_in = 1'b1; mouse_left = 1'b1;
    mouse_xpos = 12'd10; mouse_ypos = 12'd0;
    tick_cycle();
    rst = 1'b0;
    tick_cycle();
    tick_cycle();
    tick_cycle();
    check("no_false_tick_y_a", int'(ypos_a), 0);
    vsync_in = 1'b0;
    tick_cycle();
    vsync_in = 1'b1;
    tick_cycle();
    check("first_real_tick_y_a", int'(ypos_a), 1);
    $display("vsync held through reset: a_y=%0d after first real edge", ypos_a);

    // Randomized run against the model.
    rst = 1'b1; vsync_in = 1'b0; mouse_left = 1'b0;
    tick_cycle();
    rst = 1'b0;
    frame_len = 4; frame_pos = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) mouse_left = ~mouse_left;
      mouse_xpos = 12'($urandom_range(0, 4095));
      mouse_ypos = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 1023))
                                                : 12'($urandom_range(0, 4095));
      vsync_in = (frame_pos < 2) ? 1'b1 : 1'b0;
      frame_pos++;
      if (frame_pos >= frame_len) begin
        frame_pos = 0;
        frame_len = $urandom_range(3, 8);
      end
      rst = ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0;
      tick_cycle();
      rst = 1'b0;
    end
    $display("random: 4000 cycles compared against model");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
